down_count_ctrl: RTL and testbench
==================================

DOWN_COUNT_CTRL -- requirements
Module: down_count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  start a countdown, sampled on rising edge.
REQ-005 SHALL have port load_val  input  WIDTH  start value, captured when start is accepted.
REQ-006 SHALL have port pause  input  1  level-sensitive hold of the countdown.
REQ-007 SHALL have port abort  input  1  synchronous cancel, highest-priority input.
REQ-008 SHALL have port auto_reload  input  1  restart from the captured value after terminal count.
REQ-009 SHALL have port count  output  WIDTH  current counter value, registered.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-011 SHALL have port done  output  1  one-cycle terminal-count pulse, registered.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 IDLE SHALL hold count=0, busy=0, done=0.
REQ-014 IDLE with start=1, abort=0 and load_val!=0 SHALL, on that edge, capture load_val into reload_reg, set count=load_val and go to RUN.
REQ-015 IDLE with start=1 and load_val=0 SHALL go to DONE, with count=0, on that edge.
REQ-016 RUN with pause=0 SHALL decrement count by 1 per edge; pause=1 SHALL hold count, with busy remaining 1.
REQ-017 RUN with count=1 and pause=0 SHALL set count=0 and enter DONE on that edge.
REQ-018 Count SHALL never wrap: no decrement occurs from 0.
REQ-019 DONE SHALL last exactly one cycle with done=1 and count=0.
REQ-020 From DONE, if auto_reload=1, the next edge SHALL set count=reload_reg and go to RUN.
REQ-021 From DONE, if auto_reload=0, the next edge SHALL go to IDLE.
REQ-022 From DONE, if auto_reload=1 and reload_reg=0, the next edge SHALL stay in DONE with done=1.
REQ-023 Latency: start accepted at edge N with load_val=L>0 SHALL give done=1 in the cycle after edge N+L when pause is never asserted.
REQ-024 Auto-reload period SHALL be L+1 cycles.
REQ-025 Start while busy SHALL be ignored; reload_reg SHALL be unchanged.
REQ-026 Changes on load_val while busy SHALL be ignored.
REQ-027 Abort=1 in any state SHALL, on that edge, go to IDLE with count=0 and done=0.
REQ-028 Abort SHALL win over start, pause and auto_reload in the same cycle.
REQ-029 Pause during DONE SHALL have no effect.
REQ-030 Pause SHALL only affect RUN.

Reset
REQ-031 rst=0 SHALL asynchronously force state=IDLE, count=0, reload_reg=0, busy=0 and done=0.
REQ-032 Reset asserted mid-countdown SHALL discard the countdown; no done pulse SHALL follow.
REQ-033 After rst deasserts, the first accepted start SHALL behave per REQ-014/015.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-035 The datapath SHALL be a sub-module dcnt_core with ports clk, rst, load, load_val, en and count.
- load has priority over en.
- en decrements by 1.
REQ-036 down_count_ctrl SHALL contain the FSM, reload_reg and done/busy generation only.

Verification
REQ-037 Load 5, no pause -> count 5,4,3,2,1,0; done=1 for one cycle while count=0; then IDLE with busy=0.
REQ-038 Load 3, pause held 2 cycles at count=2 -> count sequence 3,2,2,2,1,0; done is 2 cycles later than in the unpaused case.
REQ-039 Load 2, auto_reload=1 -> count 2,1,0,2,1,0,...; done every 3 cycles; drop auto_reload -> IDLE after the next DONE.
REQ-040 Load 0 -> single done pulse the next cycle, count stays 0; start during RUN with load_val=9 -> ignored, countdown unaffected.
REQ-041 Abort with start in the same cycle at count=4 -> IDLE, count=0, no done.
REQ-042 rst low asynchronously mid-count at count=6 of load 9 -> outputs reset immediately; no done after release.

Source files
------------

// File: rtl/down_count_ctrl_pkg.sv
// Shared definitions for the down-counter controller: FSM state encoding
// and the default counter width.
package down_count_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dcnt_core.sv
// Counter datapath: synchronous load with priority over a saturating
// decrement that never wraps below zero.
module dcnt_core
   import down_count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/down_count_ctrl.sv
// Countdown controller: IDLE/RUN/DONE sequencing, reload value capture and
// busy/done generation around the dcnt_core datapath.
module down_count_ctrl
   import down_count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             pause,
   input  logic             abort,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_reloadReg;
   logic             r_busy;
   logic             r_done;
   logic             w_load;
   logic [WIDTH-1:0] w_loadVal;
   logic             w_en;
   logic             w_capture;
   logic [WIDTH-1:0] w_count;

   dcnt_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .load_val (w_loadVal),
      .en       (w_en),
      .count    (w_count)
   );

   // Abort overrides everything by loading zero and returning to IDLE.
   always_comb begin
      w_nextState = r_state;
      w_load      = 1'b0;
      w_loadVal   = '0;
      w_en        = 1'b0;
      w_capture   = 1'b0;
      if (abort) begin
         w_nextState = IDLE;
         w_load      = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  w_capture   = 1'b1;
                  w_load      = 1'b1;
                  w_loadVal   = load_val;
                  w_nextState = (load_val != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (!pause) begin
                  w_en = 1'b1;
                  if (w_count <= WIDTH'(1)) begin
                     w_nextState = DONE;
                  end
               end
            end
            DONE: begin
               // A zero reload value keeps re-entering DONE while auto_reload holds.
               if (auto_reload) begin
                  w_load      = 1'b1;
                  w_loadVal   = r_reloadReg;
                  w_nextState = (r_reloadReg != '0) ? RUN : DONE;
               end else begin
                  w_nextState = IDLE;
               end
            end
            default: begin
               w_nextState = IDLE;
               w_load      = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_busy  <= (w_nextState != IDLE);
         r_done  <= (w_nextState == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reloadReg <= '0;
      end else if (w_capture) begin
         r_reloadReg <= load_val;
      end
   end

   assign count = w_count;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule

// File: tb/tb_down_count_ctrl.sv
// Scoreboard bench for down_count_ctrl: each test task pushes the expected
// count/busy/done for a cycle when it drives stimulus and pops it after the edge.
module tb_down_count_ctrl;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic [WIDTH-1:0] cnt;
      logic             bsy;
      logic             dn;
   } obs_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             pause;
   logic             abort;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   obs_t expQ[$];
   int   nVectors     = 0;
   int   nMiscompares = 0;

   down_count_ctrl #(
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .load_val    (load_val),
      .pause       (pause),
      .abort       (abort),
      .auto_reload (auto_reload),
      .count       (count),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input int c, input logic b, input logic d);
      obs_t o;
      o.cnt = WIDTH'(c);
      o.bsy = b;
      o.dn  = d;
      return o;
   endfunction

   // Drive one cycle of inputs at the falling edge, record the expected
   // result, then sample point is 1 time unit after the rising edge.
   task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] lv,
                                input logic pa, input logic ab, input logic ar,
                                input obs_t want);
      @(negedge clk);
      start       = st;
      load_val    = lv;
      pause       = pa;
      abort       = ab;
      auto_reload = ar;
      expQ.push_back(want);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t got, want;
      rst = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      load_val = 4'd5;
      expQ.push_back(mk(0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      got  = {count, busy, done};
      want = expQ.pop_front();
      nVectors++;
      if (got !== want) begin
         nMiscompares++;
         $display("[TB] FAIL reset_hold count/busy/done got %0d/%b/%b want %0d/%b/%b",
                  got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, mk(0, 1'b0, 1'b0));
      got  = {count, busy, done};
      want = expQ.pop_front();
      nVectors++;
      if (got !== want) begin
         nMiscompares++;
         $display("[TB] FAIL reset_idle count/busy/done got %0d/%b/%b want %0d/%b/%b",
                  got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
      end
   endtask

   // Load 5: 5,4,3,2,1,0 with done while 0, then IDLE.
   task automatic test_countdown();
      obs_t got, want;
      for (int i = 0; i <= 6; i++) begin
         if (i < 5)       want = mk(5 - i, 1'b1, 1'b0);
         else if (i == 5) want = mk(0, 1'b1, 1'b1);
         else             want = mk(0, 1'b0, 1'b0);
         applyStimulus(i == 0, 4'd5, 1'b0, 1'b0, 1'b0, want);
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL countdown[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
   endtask

   // Load 3 with pause for two cycles at count 2; pause in DONE is ignored.
   task automatic test_pause();
      obs_t got, want;
      logic pa;
      for (int i = 0; i <= 6; i++) begin
         pa = (i == 2) || (i == 3) || (i == 6);
         case (i)
            0:       want = mk(3, 1'b1, 1'b0);
            1, 2, 3: want = mk(2, 1'b1, 1'b0);
            4:       want = mk(1, 1'b1, 1'b0);
            5:       want = mk(0, 1'b1, 1'b1);
            default: want = mk(0, 1'b0, 1'b0);
         endcase
         applyStimulus(i == 0, 4'd3, pa, 1'b0, 1'b0, want);
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL pause[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
   endtask

   // Load 2 with auto_reload: period 3; a start with load_val=7 mid-run is ignored.
   task automatic test_auto_reload();
      obs_t got, want;
      for (int i = 0; i <= 9; i++) begin
         if (i < 9) want = mk(2 - (i % 3), 1'b1, (i % 3) == 2);
         else       want = mk(0, 1'b0, 1'b0);
         applyStimulus((i == 0) || (i == 4), (i == 0) ? 4'd2 : 4'd7, 1'b0, 1'b0, i < 9, want);
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL auto_reload[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
   endtask

   // Zero load, zero load with auto_reload held, then a start during RUN.
   task automatic test_zero_load();
      obs_t             got, want;
      logic             st, ar;
      logic [WIDTH-1:0] lv;
      for (int i = 0; i <= 9; i++) begin
         st = (i == 0) || (i == 2) || (i == 5) || (i == 6);
         ar = (i == 2) || (i == 3);
         lv = (i == 5) ? 4'd3 : ((i == 6) ? 4'd9 : 4'd0);
         case (i)
            0, 2, 3: want = mk(0, 1'b1, 1'b1);
            5:       want = mk(3, 1'b1, 1'b0);
            6:       want = mk(2, 1'b1, 1'b0);
            7:       want = mk(1, 1'b1, 1'b0);
            8:       want = mk(0, 1'b1, 1'b1);
            default: want = mk(0, 1'b0, 1'b0);
         endcase
         applyStimulus(st, lv, 1'b0, 1'b0, ar, want);
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL zero_load[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
   endtask

   // Abort with start/pause/auto_reload at count 4, then abort in DONE.
   task automatic test_abort();
      obs_t             got, want;
      logic             st, pa, ab, ar;
      logic [WIDTH-1:0] lv;
      for (int i = 0; i <= 8; i++) begin
         st = (i == 0) || (i == 3) || (i == 5);
         lv = (i == 0) ? 4'd6 : ((i == 3) ? 4'd5 : 4'd1);
         pa = (i == 3);
         ab = (i == 3) || (i == 7);
         ar = (i == 3) || (i == 5) || (i == 6) || (i == 7);
         case (i)
            0:       want = mk(6, 1'b1, 1'b0);
            1:       want = mk(5, 1'b1, 1'b0);
            2:       want = mk(4, 1'b1, 1'b0);
            5:       want = mk(1, 1'b1, 1'b0);
            6:       want = mk(0, 1'b1, 1'b1);
            default: want = mk(0, 1'b0, 1'b0);
         endcase
         applyStimulus(st, lv, pa, ab, ar, want);
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL abort[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
   endtask

   // Asynchronous reset at count 6 of load 9; no done afterwards; then a fresh start.
   task automatic test_midcount_reset();
      obs_t got, want;
      for (int i = 0; i <= 3; i++) begin
         applyStimulus(i == 0, 4'd9, 1'b0, 1'b0, 1'b0, mk(9 - i, 1'b1, 1'b0));
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL midreset_run[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
      @(negedge clk);
      #2;
      rst = 1'b0;
      expQ.push_back(mk(0, 1'b0, 1'b0));
      #1;
      got  = {count, busy, done};
      want = expQ.pop_front();
      nVectors++;
      if (got !== want) begin
         nMiscompares++;
         $display("[TB] FAIL midreset_async count/busy/done got %0d/%b/%b want %0d/%b/%b",
                  got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i <= 13; i++) begin
         case (i)
            10:      want = mk(2, 1'b1, 1'b0);
            11:      want = mk(1, 1'b1, 1'b0);
            12:      want = mk(0, 1'b1, 1'b1);
            default: want = mk(0, 1'b0, 1'b0);
         endcase
         applyStimulus(i == 10, 4'd2, 1'b0, 1'b0, 1'b0, want);
         got  = {count, busy, done};
         want = expQ.pop_front();
         nVectors++;
         if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL midreset_after[%0d] count/busy/done got %0d/%b/%b want %0d/%b/%b",
                     i, got.cnt, got.bsy, got.dn, want.cnt, want.bsy, want.dn);
         end
      end
   endtask

   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      load_val    = '0;
      pause       = 1'b0;
      abort       = 1'b0;
      auto_reload = 1'b0;
      $display("[TB] starting down_count_ctrl tests");
      test_reset();
      test_countdown();
      test_pause();
      test_auto_reload();
      test_zero_load();
      test_abort();
      test_midcount_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
